axi4_console_port: RTL and testbench
====================================

AXI4_CONSOLE_PORT -- requirements
Module: axi4_console_port

Interface
REQ-001 SHALL have parameter DEPTH, default 8, TX FIFO depth in bytes; power of two, 2..16.
REQ-002 SHALL have parameter PASS_MAGIC, default 32'd123456789, value that sets tests_passed.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports mem_axi_awvalid in 1, mem_axi_awready out 1, mem_axi_awaddr in 32: AXI4-Lite write address.
REQ-006 SHALL have ports mem_axi_wvalid in 1, mem_axi_wready out 1, mem_axi_wdata in 32, mem_axi_wstrb in 4: write data.
REQ-007 SHALL have ports mem_axi_bvalid out 1, mem_axi_bready in 1: write response, always OKAY, no bresp port.
REQ-008 SHALL have ports mem_axi_arvalid in 1, mem_axi_arready out 1, mem_axi_araddr in 32: read address.
REQ-009 SHALL have ports mem_axi_rvalid out 1, mem_axi_rready in 1, mem_axi_rdata out 32: read data.
REQ-010 SHALL have ports out_valid out 1, out_ready in 1, out_data out 8: console byte stream, valid/ready.
REQ-011 SHALL have port tests_passed  output  1  sticky pass flag.

Function
REQ-012 SHALL decode only addr[3:2]: 0 = TXDATA (W), 1 = STATUS (R), 2 = PASS (W/R), 3 = unmapped; upper address bits ignored.
REQ-013 SHALL accept AW and W independently: awready = 1 when no address latched and !bvalid; wready = 1 when no data latched and !bvalid; handshake latches the channel.
REQ-014 SHALL commit a write in the first cycle both address and data are latched and !bvalid, then assert bvalid the next cycle; AW and W in the same cycle give bvalid 2 cycles after handshake.
REQ-015 SHALL, on TXDATA commit with wstrb[0]=1, push wdata[7:0]; with wstrb[0]=0 the write completes without push.
REQ-016 SHALL stall a TXDATA commit while FIFO is full: latches held, no bvalid, awready/wready low, until a pop frees an entry.
REQ-017 SHALL, on PASS commit with wstrb=4'b1111 and wdata==PASS_MAGIC, set tests_passed; other values leave it unchanged; it never clears except by reset.
REQ-018 SHALL ignore writes to unmapped offset 3 but still respond with bvalid.
REQ-019 SHALL hold bvalid high until bready; clears in the cycle after the bvalid&&bready edge; next write may latch one cycle later.
REQ-020 SHALL assert arready when !rvalid and no read pending; rvalid high the cycle after the AR handshake; rdata stable until rvalid&&rready.
REQ-021 SHALL return STATUS = {24'b0, count[4:0], 1'b0, full, empty}; PASS reads {31'b0, tests_passed}; TXDATA and unmapped read 0.
REQ-022 SHALL drive out_valid = !empty and out_data = head entry combinationally from FIFO state; pop on out_valid&&out_ready.
REQ-023 SHALL use read/write pointers wrapping modulo DEPTH; count in 0..DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-024 SHALL, on simultaneous push and pop with FIFO neither empty nor full, keep count unchanged; when full, a pop in the stall cycle lets the stalled push commit the following cycle, never same cycle.
REQ-025 SHALL let a read of STATUS in the same cycle as a push/pop report the pre-update values.
REQ-026 SHALL process reads and writes concurrently with no mutual ordering.

Reset
REQ-027 SHALL, while reset is high, drive awready, wready, bvalid, arready, rvalid, out_valid, tests_passed to 0, rdata and out_data to 0, empty the FIFO, and drop latched AW/W/AR state.
REQ-028 SHALL abandon any in-flight or stalled transaction on reset without issuing its response.
REQ-029 SHALL assert awready, wready, arready in the first cycle after reset deasserts.

Verification
REQ-030 Write 0x41 to TXDATA, out_ready=1 -> bvalid 2 cycles after AW/W handshake; out_data=0x41, out_valid for exactly one cycle.
REQ-031 out_ready=0, write 9 bytes 0x30..0x38 with DEPTH=8 -> 9th write gets no bvalid; STATUS reads 0x0000_0042; raising out_ready completes it; bytes emerge in order 0x30..0x38.
REQ-032 W channel 3 cycles before AW -> data latched, bvalid one cycle after commit; single push only.
REQ-033 Write 123456789 to PASS -> tests_passed=1; then write 0 -> stays 1; read PASS returns 1.
REQ-034 Write wstrb=4'b0000 to TXDATA and any write to offset 0xC -> bvalid returned, FIFO count stays 0.
REQ-035 Reset asserted while a write is stalled on full FIFO -> no bvalid, FIFO empty, STATUS reads 0x0000_0001 after reset.

Source files
------------

// File: rtl/axi4_console_port.sv
// AXI4-Lite console peripheral: TXDATA writes feed a byte FIFO drained as a valid/ready stream,
// STATUS reports FIFO occupancy, and a magic write to PASS raises a sticky tests_passed flag.
module axi4_console_port #(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        tests_passed
);
  localparam int         PW      = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic          aw_valid_q, aw_valid_d;
  logic [1:0]    aw_off_q, aw_off_d;
  logic          w_valid_q, w_valid_d;
  logic [31:0]   w_data_q, w_data_d;
  logic [3:0]    w_strb_q, w_strb_d;
  logic          b_valid_q, b_valid_d;
  logic          r_valid_q, r_valid_d;
  logic [31:0]   r_data_q, r_data_d;
  logic          pass_q, pass_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic [7:0]    mem_q [DEPTH];

  logic full, empty, pending, stall, commit, push, pop;
  logic aw_hs, w_hs, ar_hs;
  logic unused_addr;

  assign unused_addr = ^{mem_axi_awaddr[31:4], mem_axi_awaddr[1:0],
                         mem_axi_araddr[31:4], mem_axi_araddr[1:0]};

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == 5'd0);

  // A TXDATA write with a byte to push waits while the FIFO is full; the
  // full flag is the registered one, so a pop only unblocks it next cycle.
  always_comb begin
    pending = aw_valid_q && w_valid_q && !b_valid_q;
    stall   = pending && (aw_off_q == 2'd0) && w_strb_q[0] && full;
    commit  = pending && !stall;
    push    = commit && (aw_off_q == 2'd0) && w_strb_q[0];
    pop     = !empty && out_ready;
    aw_hs   = mem_axi_awvalid && !aw_valid_q && !b_valid_q;
    w_hs    = mem_axi_wvalid && !w_valid_q && !b_valid_q;
    ar_hs   = mem_axi_arvalid && !r_valid_q;
  end

  always_comb begin
    aw_valid_d = aw_valid_q;
    aw_off_d   = aw_off_q;
    w_valid_d  = w_valid_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    b_valid_d  = b_valid_q;
    pass_d     = pass_q;
    if (commit) begin
      aw_valid_d = 1'b0;
      w_valid_d  = 1'b0;
      b_valid_d  = 1'b1;
    end else if (b_valid_q && mem_axi_bready) begin
      b_valid_d = 1'b0;
    end
    if (aw_hs) begin
      aw_valid_d = 1'b1;
      aw_off_d   = mem_axi_awaddr[3:2];
    end
    if (w_hs) begin
      w_valid_d = 1'b1;
      w_data_d  = mem_axi_wdata;
      w_strb_d  = mem_axi_wstrb;
    end
    if (commit && (aw_off_q == 2'd2) && (w_strb_q == 4'hF) && (w_data_q == PASS_MAGIC))
      pass_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + 5'(push) - 5'(pop);
  end

  // Read data is captured from pre-update state at the AR handshake.
  always_comb begin
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    if (ar_hs) begin
      r_valid_d = 1'b1;
      case (mem_axi_araddr[3:2])
        2'd1:    r_data_d = {24'b0, count_q, 1'b0, full, empty};
        2'd2:    r_data_d = {31'b0, pass_q};
        default: r_data_d = 32'h0;
      endcase
    end else if (r_valid_q && mem_axi_rready) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_valid_q <= 1'b0;
      aw_off_q   <= 2'd0;
      w_valid_q  <= 1'b0;
      w_data_q   <= 32'h0;
      w_strb_q   <= 4'h0;
      b_valid_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= 32'h0;
      pass_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
    end else begin
      aw_valid_q <= aw_valid_d;
      aw_off_q   <= aw_off_d;
      w_valid_q  <= w_valid_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      b_valid_q  <= b_valid_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      pass_q     <= pass_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= w_data_q[7:0];
  end

  // Outputs are forced idle for the whole reset window, including its first cycle.
  assign mem_axi_awready = !reset && !aw_valid_q && !b_valid_q;
  assign mem_axi_wready  = !reset && !w_valid_q && !b_valid_q;
  assign mem_axi_bvalid  = !reset && b_valid_q;
  assign mem_axi_arready = !reset && !r_valid_q;
  assign mem_axi_rvalid  = !reset && r_valid_q;
  assign mem_axi_rdata   = reset ? 32'h0 : r_data_q;
  assign out_valid       = !reset && !empty;
  assign out_data        = (reset || empty) ? 8'h00 : mem_q[rd_ptr_q];
  assign tests_passed    = !reset && pass_q;

endmodule

// File: tb/tb_axi4_console_port.sv
// Directed bench for axi4_console_port: stimulus pushes expected bytes / read data into
// queues, and a negedge monitor pops and compares whenever the DUT hands something out.
module tb_axi4_console_port;
  logic        clk = 1'b0;
  logic        reset;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        out_valid, out_ready, tests_passed;
  logic [7:0]  out_data;

  int total = 0;
  int bad = 0;
  int b_count = 0;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_rd[$];

  always #5 clk = ~clk;

  axi4_console_port #(.DEPTH(8), .PASS_MAGIC(32'd123456789)) dut (
    .clk(clk), .reset(reset),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata),
    .mem_axi_wstrb(wstrb), .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tests_passed(tests_passed)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got 0x%08h expected nothing here", name, act);
  endtask

  // Monitor: one line per delivered byte, read beat or write response.
  always @(negedge clk) begin
    if (bvalid && bready) begin
      b_count++;
      $display("  bresp #%0d", b_count);
    end
    if (out_valid && out_ready) begin
      $display("  out byte 0x%02h", out_data);
      if (exp_bytes.size() == 0) fail_evt("out_unexpected", {24'b0, out_data});
      else chk("out_byte", {24'b0, out_data}, {24'b0, exp_bytes.pop_front()});
    end
    if (rvalid && rready) begin
      $display("  read data 0x%08h", rdata);
      if (exp_rd.size() == 0) fail_evt("rd_unexpected", rdata);
      else chk("rd_data", rdata, exp_rd.pop_front());
    end
  end

  task automatic apply_reset(input int cycles);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_awready", {31'b0, awready}, 32'd0);
    chk("rst_wready", {31'b0, wready}, 32'd0);
    chk("rst_arready", {31'b0, arready}, 32'd0);
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_tests_passed", {31'b0, tests_passed}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_out_data", {24'b0, out_data}, 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", {31'b0, awready}, 32'd1);
    chk("post_rst_wready", {31'b0, wready}, 32'd1);
    chk("post_rst_arready", {31'b0, arready}, 32'd1);
  endtask

  task automatic issue_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit do_aw, input bit do_w);
    logic aw_hs, w_hs;
    @(posedge clk); #1;
    if (do_aw) begin awvalid = 1'b1; awaddr = addr; end
    if (do_w) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
    end
    if (awvalid || wvalid) begin
      fail_evt("write_handshake_timeout", addr);
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
    $display("  write addr=0x%08h data=0x%08h strb=%b", addr, data, strb);
  endtask

  // lat counts clock edges from the handshake edge to the cycle bvalid is seen.
  task automatic wait_b(input int budget, output bit got, output int lat);
    got = 1'b0;
    lat = 1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (bvalid) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  task automatic write_full(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output int lat);
    bit got;
    issue_write(addr, data, strb, 1'b1, 1'b1);
    wait_b(10, got, lat);
    chk("bvalid_seen", {31'b0, got}, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp);
    bit hs;
    exp_rd.push_back(exp);
    @(posedge clk); #1;
    arvalid = 1'b1;
    araddr  = addr;
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      hs = arready;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (!hs) begin
      fail_evt("ar_handshake_timeout", addr);
      void'(exp_rd.pop_back());
    end
    for (int i = 0; i < 10 && exp_rd.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_rd.size() != 0) begin
      fail_evt("rvalid_timeout", addr);
      exp_rd.delete();
    end
  endtask

  task automatic drain_bytes(input string name);
    for (int i = 0; i < 60 && exp_bytes.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk(name, exp_bytes.size(), 32'd0);
    exp_bytes.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  got;
    int  bsnap;
    reset = 1'b1;
    awvalid = 1'b0; awaddr = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0;
    bready = 1'b1;
    arvalid = 1'b0; araddr = '0;
    rready = 1'b1;
    out_ready = 1'b0;

    apply_reset(3);
    do_read(32'h4, 32'h0000_0001);
    do_read(32'h8, 32'h0000_0000);

    // Single TXDATA byte with bvalid latency and one-cycle out_valid.
    out_ready = 1'b1;
    exp_bytes.push_back(8'h41);
    write_full(32'h0, 32'h41, 4'b0001, lat);
    chk("txdata_b_latency", lat, 32'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("txdata_out_idle", {31'b0, out_valid}, 32'd0);
    drain_bytes("txdata_bytes_left");

    // W leads AW by three cycles.
    exp_bytes.push_back(8'h5A);
    issue_write(32'h0, 32'h0000_005A, 4'b0001, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("wfirst_wready_low", {31'b0, wready}, 32'd0);
      chk("wfirst_no_bvalid", {31'b0, bvalid}, 32'd0);
    end
    issue_write(32'h0, 32'h0, 4'b0000, 1'b1, 1'b0);
    wait_b(10, got, lat);
    chk("wfirst_bvalid", {31'b0, got}, 32'd1);
    chk("wfirst_b_latency", lat, 32'd2);
    repeat (4) @(posedge clk);
    drain_bytes("wfirst_bytes_left");

    // No-push writes: strobe off, unmapped offset; upper address bits ignored.
    write_full(32'h0, 32'h0000_0077, 4'b0000, lat);
    write_full(32'hC, 32'hFFFF_FFFF, 4'b1111, lat);
    do_read(32'h4, 32'h0000_0001);
    do_read(32'hC, 32'h0000_0000);
    do_read(32'h0, 32'h0000_0000);
    exp_bytes.push_back(8'h7E);
    write_full(32'hF000_0000, 32'h0000_007E, 4'b0001, lat);
    drain_bytes("hiaddr_bytes_left");

    // Fill to full, ninth write stalls until the sink drains.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_bytes.push_back(8'h30 + 8'(k));
      write_full(32'h0, 32'h30 + k, 4'b0001, lat);
    end
    exp_bytes.push_back(8'h38);
    issue_write(32'h0, 32'h38, 4'b0001, 1'b1, 1'b1);
    wait_b(8, got, lat);
    chk("stall_no_bvalid", {31'b0, got}, 32'd0);
    @(negedge clk);
    chk("stall_awready_low", {31'b0, awready}, 32'd0);
    chk("stall_wready_low", {31'b0, wready}, 32'd0);
    do_read(32'h4, 32'h0000_0042);
    out_ready = 1'b1;
    wait_b(20, got, lat);
    chk("stall_release_bvalid", {31'b0, got}, 32'd1);
    drain_bytes("stall_bytes_left");
    do_read(32'h4, 32'h0000_0001);

    // Sticky pass flag.
    write_full(32'h8, 32'd123456789, 4'b1111, lat);
    @(negedge clk);
    chk("pass_set", {31'b0, tests_passed}, 32'd1);
    write_full(32'h8, 32'd0, 4'b1111, lat);
    @(negedge clk);
    chk("pass_sticky", {31'b0, tests_passed}, 32'd1);
    do_read(32'h8, 32'h0000_0001);

    // Reset while a write is stalled on a full FIFO.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) write_full(32'h0, 32'h60 + k, 4'b0001, lat);
    issue_write(32'h0, 32'h68, 4'b0001, 1'b1, 1'b1);
    wait_b(5, got, lat);
    chk("rst_stall_no_bvalid", {31'b0, got}, 32'd0);
    bsnap = b_count;
    apply_reset(2);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_bresp", b_count, bsnap);
    chk("rst_fifo_empty", {31'b0, out_valid}, 32'd0);
    chk("rst_pass_clear", {31'b0, tests_passed}, 32'd0);
    do_read(32'h4, 32'h0000_0001);
    chk("exp_rd_left", exp_rd.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
